// File: rtl/mult_sequencer.sv
// mult_sequencer: 32x32 -> 64-bit shift-and-add multiplier that borrows the
// shared EX-stage ALU for each accumulate step via a request/grant handshake.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   start             request a multiply (sampled only in IDLE)
//   signedOp          1 = signed, 0 = unsigned (sampled with start)
//   multA, multB      multiplicand / multiplier (sampled with start)
//   busy              multiply in progress (registered)
//   done              one-cycle pulse, hi/lo valid (registered)
//   hi, lo            product words, held until the next done
//   aluReq/aluGnt     ALU request / arbiter grant
//   aluN1, aluN2      ALU operands (accumulator, multiplicand magnitude)
//   aluCtrl           ALU control code (add when requesting, else 0)
//   aluResult         combinational ALU result, same cycle
module mult_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        signedOp,
  input  logic [31:0] multA,
  input  logic [31:0] multB,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        aluReq,
  input  logic        aluGnt,
  output logic [31:0] aluN1,
  output logic [31:0] aluN2,
  output logic [3:0]  aluCtrl,
  input  logic [31:0] aluResult
);

  localparam logic [3:0] ALU_ADD = 4'b0010;

  typedef enum logic [1:0] {IDLE, ADD, FIX} stateT;

  stateT       state, stateNext;
  logic [31:0] acc, mplier, mcand;
  logic [5:0]  count;
  logic        neg;
  logic        step;     // an ADD iteration completes this cycle
  logic        carry;    // carry-out of acc + mcand, recovered from the wrapped sum
  logic [63:0] prod, prodFix;

  always_comb begin
    stateNext = state;
    aluReq    = 1'b0;
    aluN1     = 32'd0;
    aluN2     = 32'd0;
    aluCtrl   = 4'b0000;
    step      = 1'b0;
    case (state)
      IDLE: if (start) stateNext = ADD;
      ADD: begin
        if (mplier[0]) begin
          aluReq  = 1'b1;
          aluN1   = acc;
          aluN2   = mcand;
          aluCtrl = ALU_ADD;
          step    = aluGnt;   // no grant: hold everything and retry
        end else begin
          step    = 1'b1;
        end
        if (step && count == 6'd31) stateNext = FIX;
      end
      FIX:     stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  assign carry   = (aluResult < acc);
  assign prod    = {acc, mplier};
  assign prodFix = neg ? (~prod + 64'd1) : prod;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      acc    <= 32'd0;
      mplier <= 32'd0;
      mcand  <= 32'd0;
      count  <= 6'd0;
      neg    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= 32'd0;
      lo     <= 32'd0;
    end else begin
      state <= stateNext;
      done  <= 1'b0;
      case (state)
        IDLE: if (start) begin
          // magnitude of 0x80000000 wraps to itself, read as unsigned
          mcand  <= (signedOp && multA[31]) ? -multA : multA;
          mplier <= (signedOp && multB[31]) ? -multB : multB;
          neg    <= signedOp & (multA[31] ^ multB[31]);
          acc    <= 32'd0;
          count  <= 6'd0;
          busy   <= 1'b1;
        end
        ADD: if (step) begin
          if (mplier[0]) {acc, mplier} <= {carry, aluResult, mplier[31:1]};
          else           {acc, mplier} <= {1'b0, acc, mplier[31:1]};
          count <= count + 6'd1;
        end
        FIX: begin
          {hi, lo} <= prodFix;
          done     <= 1'b1;
          busy     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_sequencer.sv
// Scoreboard bench for mult_sequencer: stimulus pushes hand-computed products
// and latencies; an independent monitor pops and checks on every done pulse.
module tb_mult_sequencer;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, signedOp = 1'b0, aluGnt = 1'b1;
  logic [31:0] multA = 32'd0, multB = 32'd0;
  logic        busy, done, aluReq;
  logic [31:0] hi, lo, aluN1, aluN2, aluResult;
  logic [3:0]  aluCtrl;

  mult_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .signedOp(signedOp),
    .multA(multA), .multB(multB), .busy(busy), .done(done), .hi(hi), .lo(lo),
    .aluReq(aluReq), .aluGnt(aluGnt), .aluN1(aluN1), .aluN2(aluN2),
    .aluCtrl(aluCtrl), .aluResult(aluResult)
  );

  // shared ALU stand-in: add when asked, otherwise zero
  assign aluResult = (aluCtrl == 4'b0010) ? aluN1 + aluN2 : 32'd0;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0, bad = 0, doneSeen = 0;

  typedef struct {
    logic [31:0] hi, lo;
    int          issue, lat;
    string       name;
  } expT;
  expT sb[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // monitor
  initial forever begin
    @(negedge clk);
    if (done === 1'b1) begin
      doneSeen++;
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpectedDone: got done=1 at cycle %0d want none", cyc);
      end else begin
        expT e;
        e = sb.pop_front();
        chk({e.name, "_hi"},  {32'd0, hi}, {32'd0, e.hi});
        chk({e.name, "_lo"},  {32'd0, lo}, {32'd0, e.lo});
        chk({e.name, "_lat"}, 64'(cyc - e.issue), 64'(e.lat));
      end
    end
  end

  // Called just after a negedge; returns at the negedge of the done cycle so
  // the next call issues start in the done cycle itself.
  task automatic doMult(input logic sOp, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input int lat,
                        input int stall, input int junkCyc, input string name);
    int busyCnt = 0;
    int k = 0;
    signedOp = sOp; multA = a; multB = b; start = 1'b1;
    sb.push_back('{eh, el, cyc, lat, name});
    @(negedge clk);
    for (int i = 0; i < 200 && done !== 1'b1; i++) begin
      k = i + 1;
      aluGnt = !(stall > 0 && k <= stall);
      if (k == junkCyc) begin
        start = 1'b1; signedOp = 1'b1; multA = 32'h9; multB = 32'h9;
      end else start = 1'b0;
      if (stall > 0 && k <= stall + 1) begin
        chk({name, "_stallReq"},  {63'd0, aluReq}, 64'd1);
        chk({name, "_stallN1"},   {32'd0, aluN1}, 64'd0);
        chk({name, "_stallN2"},   {32'd0, aluN2}, {32'd0, a});
        chk({name, "_stallCtrl"}, {60'd0, aluCtrl}, 64'd2);
      end
      if (busy === 1'b1) busyCnt++;
      @(negedge clk);
    end
    start = 1'b0; aluGnt = 1'b1;
    if (done !== 1'b1) begin
      total++; bad++;
      $display("FAIL %s_timeout: got no done want done within 200 cycles", name);
    end
    chk({name, "_busyCycles"}, 64'(busyCnt), 64'(lat - 1));
    chk({name, "_busyAtDone"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    int c0, seen;
    repeat (3) @(negedge clk);
    chk("rst_busy",  {63'd0, busy}, 64'd0);
    chk("rst_done",  {63'd0, done}, 64'd0);
    chk("rst_hilo",  {hi, lo}, 64'd0);
    chk("rst_req",   {63'd0, aluReq}, 64'd0);
    chk("rst_n1n2",  {aluN1, aluN2}, 64'd0);
    chk("rst_ctrl",  {60'd0, aluCtrl}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    doMult(1'b0, 32'd7,          32'd6,          32'h00000000, 32'h0000002A, 34, 0, 0, "u7x6");
    doMult(1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE, 32'h00000001, 34, 0, 0, "carry");
    doMult(1'b1, 32'hFFFFFFFD,   32'd5,          32'hFFFFFFFF, 32'hFFFFFFF1, 34, 0, 0, "sM3x5");
    doMult(1'b1, 32'h80000000,   32'h80000000,   32'h40000000, 32'h00000000, 34, 0, 0, "sMinSq");
    doMult(1'b1, 32'hFFFFFFF9,   32'hFFFFFFFA,   32'h00000000, 32'h0000002A, 34, 0, 0, "sM7xM6");
    doMult(1'b1, 32'h7FFFFFFF,   32'h80000000,   32'hC0000000, 32'h80000000, 34, 0, 0, "sMaxMin");
    doMult(1'b0, 32'h80000000,   32'd2,          32'h00000001, 32'h00000000, 34, 0, 0, "uBigx2");
    doMult(1'b1, 32'd0,          32'hFFFFFFFF,   32'h00000000, 32'h00000000, 34, 0, 0, "s0xM1");
    doMult(1'b0, 32'd3,          32'd5,          32'h00000000, 32'h0000000F, 38, 4, 0, "stall");
    doMult(1'b0, 32'd7,          32'd6,          32'h00000000, 32'h0000002A, 34, 0, 5, "ignoreStart");

    // reset in cycle 10 of a multiply: in-flight result dropped, hi/lo cleared
    seen = doneSeen;
    c0 = cyc;
    signedOp = 1'b0; multA = 32'd9; multB = 32'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < c0 + 10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midRst_busy", {63'd0, busy}, 64'd0);
    chk("midRst_done", {63'd0, done}, 64'd0);
    chk("midRst_hilo", {hi, lo}, 64'd0);
    chk("midRst_req",  {63'd0, aluReq}, 64'd0);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("midRst_noDone", 64'(doneSeen - seen), 64'd0);
    chk("sbEmpty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult_sequencer.md
# mult_sequencer

Multi-cycle 32x32 multiply sequencer that produces a 64-bit HI/LO product by shift-and-add. It borrows the shared primary ALU's add operation for each accumulate step through a request/grant handshake. It sits beside the EX stage. The EX-stage arbiter owns the ALU and grants it to this block only in cycles where the pipeline does not need it. Signed and unsigned multiplies are both supported; sign handling is local to this block.

## Interface
Parameters:
- none (data width fixed at 32, ALU add code fixed at 4'b0010)

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  request a multiply; sampled only in IDLE.
- signedOp  in  1  1 = signed (mult), 0 = unsigned (multu); sampled with start.
- multA  in  32  multiplicand; sampled with start.
- multB  in  32  multiplier; sampled with start.
- busy  out  1  high while a multiply is in progress.
- done  out  1  one-cycle pulse; hi/lo are valid in this cycle.
- hi  out  32  upper product word; holds until the next done.
- lo  out  32  lower product word; holds until the next done.
- aluReq  out  1  this block needs the ALU in the current cycle.
- aluGnt  in  1  arbiter grant; meaningful only while aluReq = 1.
- aluN1  out  32  ALU operand 1 (accumulator).
- aluN2  out  32  ALU operand 2 (multiplicand magnitude).
- aluCtrl  out  4  ALU control code.
- aluResult  in  32  combinational ALU output, same cycle.

## Operation
- States: IDLE, ADD, FIX.
- Internal registers:
  - acc[31:0]
  - mplier[31:0]
  - mcand[31:0]
  - count[5:0]
  - neg
- **IDLE, start = 1**: capture the operands.
  - mcand = |multA| and mplier = |multB| when signedOp, else the raw values.
  - The magnitude of 0x80000000 is 0x80000000, read as unsigned.
  - neg = signedOp & (multA[31] ^ multB[31]).
  - acc = 0, count = 0, go to ADD.
- **ADD, mplier[0] = 0**: no ALU use; aluReq = 0.
  - {acc, mplier} is shifted right by 1 with a 0 shifted in.
  - count increments.
- **ADD, mplier[0] = 1**: aluReq = 1 (combinational from registered state), aluN1 = acc, aluN2 = mcand, aluCtrl = 4'b0010.
  - If aluGnt = 1: carry = (aluResult < acc), unsigned compare. {acc, mplier} becomes {carry, aluResult, mplier[31:1]}, and count increments.
  - If aluGnt = 0: all registers hold (stall) and aluReq stays high.
- ADD → FIX when an iteration completes with count = 31.
- **FIX**: {hi, lo} = neg ? -{acc, mplier} (64-bit two's complement, local logic) : {acc, mplier}. done = 1, go to IDLE.
- When aluReq = 0: aluN1 = aluN2 = 0 and aluCtrl = 4'b0000.
- start while busy is ignored; no queuing.
- The 64-bit result never overflows: the magnitude product is at most 2^64 - 2^33 + 1 (unsigned) or 2^62 (signed).

## Timing
- Reset values: state IDLE; busy = 0, done = 0, hi = 0, lo = 0, aluReq = 0, aluN1 = 0, aluN2 = 0, aluCtrl = 0; internal registers cleared.
- Latency with no stalls: start sampled at the edge ending cycle 0.
  - busy is high in cycles 1..33 (32 ADD cycles plus 1 FIX cycle).
  - done is high, with hi/lo valid, in cycle 34; busy = 0 in cycle 34.
  - A new start is accepted in cycle 34.
- Each cycle with aluReq = 1 and aluGnt = 0 adds exactly one cycle.
- done and busy are registered.
- Reset has priority over everything, including mid-ADD and the FIX edge.
  - Reset returns the block to IDLE, drops aluReq the next cycle and clears hi/lo.
  - An in-flight result is discarded with no done pulse.
- aluGnt asserted while aluReq = 0 has no effect.

## Test plan
- **Unsigned 7 x 6**: signedOp = 0, permanent grant → done in cycle 34, hi = 0x00000000, lo = 0x0000002A.
- **Carry path**: unsigned 0xFFFFFFFF x 0xFFFFFFFF → hi = 0xFFFFFFFE, lo = 0x00000001.
- **Signed -3 x 5**: signedOp = 1, multA = 0xFFFFFFFD, multB = 5 → hi = 0xFFFFFFFF, lo = 0xFFFFFFF1.
- **Signed 0x80000000 x 0x80000000** → hi = 0x40000000, lo = 0x00000000.
- **Stall**: 3 x 0x00000005 with aluGnt low for 4 cycles during the first request.
  - done arrives in cycle 38.
  - aluN1/aluN2/aluCtrl are stable during the stall.
  - lo = 0x0000000F.
- **Reset and start misuse**:
  - rst_n low in cycle 10 of a multiply → no done pulse, hi = lo = 0, busy = 0 next cycle.
  - A start pulse during busy with different operands → ignored, and the original product is reported.
